// File: rtl/pattern_game_pkg.sv
// rtl/pattern_game_pkg.sv - shared enums and LFSR constants for the pattern game core
package pattern_game_pkg;

    typedef enum logic [1:0] {
        MODE_CLASSIC = 2'd0,
        MODE_TIMED   = 2'd1,
        MODE_REVERSE = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_OFF = 3'd3,
        WAIT_IN  = 3'd4,
        WAIT_REL = 3'd5,
        OVER     = 3'd6,
        WIN      = 3'd7
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step: the bit shifted out folds the taps back in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// rtl/game_lfsr.sv - free-running 16-bit Galois LFSR feeding the symbol generator
module game_lfsr
    import pattern_game_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/pattern_game_core.sv
// rtl/pattern_game_core.sv - memory-game datapath and FSM; GAME_SPEEDUP_EN shortens playback as score grows
module pattern_game_core
    import pattern_game_pkg::*;
#(
    parameter int NUM_BUTTONS    = 8,
    parameter int SYM_W          = $clog2(NUM_BUTTONS),
    parameter int MAX_LEN        = 25,
    parameter int SHOW_CYCLES    = 500,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SCORE_W        = 5
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic [NUM_BUTTONS-1:0]         buttons,
    output logic [NUM_BUTTONS-1:0]         led,
    output logic                           active,
    output logic                           game_over,
    output logic                           win,
    output logic [SCORE_W-1:0]             score,
    output logic [$clog2(MAX_LEN+1)-1:0]   level
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int SG_MAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (SG_MAX > TIMEOUT_CYCLES) ? SG_MAX : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SYM_W:0] NB = NUM_BUTTONS[SYM_W:0];

    function automatic logic [NUM_BUTTONS-1:0] onehot(input logic [SYM_W-1:0] s);
        logic [NUM_BUTTONS-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // Scan from the top so the lowest pressed index is the one that sticks.
    function automatic logic [SYM_W-1:0] lowest(input logic [NUM_BUTTONS-1:0] b);
        logic [SYM_W-1:0] r;
        r = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (b[i]) r = SYM_W'(i);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SYM_W-1:0]    key_q, key_d;
    logic                start_q;
    logic                btn_q;

    logic [SYM_W-1:0]    mem [2**LEN_W];

    logic [15:0]         lfsr;
    logic [SYM_W:0]      raw_w;
    logic [SYM_W:0]      sym_w;
    logic [SYM_W-1:0]    sym;
    logic                start_edge;
    logic                btn_any;
    logic                btn_edge;
    logic [SYM_W-1:0]    press_sym;
    logic [LEN_W-1:0]    len_m1;
    logic                last;
    logic [LEN_W-1:0]    slot;
    logic [SYM_W-1:0]    expected;
    logic [CNT_W-1:0]    on_time;
    logic                unused_bits;

    game_lfsr u_lfsr (
        .clock   (clock),
        .rst_n   (rst_n),
        .state_o (lfsr)
    );

    assign raw_w       = {1'b0, lfsr[SYM_W-1:0]};
    assign sym_w       = (raw_w >= NB) ? (raw_w - NB) : raw_w;
    assign sym         = sym_w[SYM_W-1:0];
    assign unused_bits = ^{lfsr[15:SYM_W], sym_w[SYM_W]};

    assign start_edge = start & ~start_q;
    assign btn_any    = |buttons;
    assign btn_edge   = btn_any & ~btn_q;
    assign press_sym  = lowest(buttons);

    assign len_m1   = len_q - LEN_W'(1);
    assign last     = (idx_q == len_m1);
    assign slot     = (mode_q == MODE_REVERSE) ? (len_m1 - idx_q) : idx_q;
    assign expected = mem[slot];

`ifdef GAME_SPEEDUP_EN
    localparam int STEP_ON  = SHOW_CYCLES / 8;
    localparam int FLOOR_ON = SHOW_CYCLES / 4;
    logic [31:0] cut;

    assign cut     = 32'(score_q) * 32'(STEP_ON);
    assign on_time = (cut >= 32'(SHOW_CYCLES - FLOOR_ON)) ? CNT_W'(FLOOR_ON)
                                                          : CNT_W'(32'(SHOW_CYCLES) - cut);
`else
    assign on_time = CNT_W'(SHOW_CYCLES);
`endif

    always_ff @(posedge clock) begin
        if (state_q == ADD) begin
            mem[len_q] <= sym;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_CLASSIC;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            cnt_q   <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            start_q <= start;
            btn_q   <= btn_any;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        idx_d     = idx_q;
        score_d   = score_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        led       = '0;
        active    = 1'b0;
        game_over = 1'b0;
        win       = 1'b0;

        case (state_q)
            IDLE, OVER, WIN: begin
                game_over = (state_q == OVER);
                win       = (state_q == WIN);
                if (start_edge && (mode != MODE_RSVD)) begin
                    mode_d  = mode_t'(mode);
                    len_d   = '0;
                    score_d = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                active  = 1'b1;
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                cnt_d   = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                active = 1'b1;
                led    = onehot(mem[idx_q]);
                if (cnt_q == on_time - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = SHOW_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHOW_OFF: begin
                active = 1'b1;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    if (last) begin
                        idx_d   = '0;
                        cnt_d   = CNT_W'(TIMEOUT_CYCLES);
                        state_d = WAIT_IN;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        cnt_d   = '0;
                        state_d = SHOW_ON;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IN: begin
                active = 1'b1;
                // A press in the final timed cycle is checked before the timeout.
                if (btn_edge) begin
                    key_d   = press_sym;
                    state_d = (press_sym == expected) ? WAIT_REL : OVER;
                end else if (mode_q == MODE_TIMED) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = OVER;
                    end
                end
            end
            WAIT_REL: begin
                active = 1'b1;
                led    = onehot(key_q);
                if (!btn_any) begin
                    if (last) begin
                        if (score_q != '1) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        state_d = (len_q == LEN_W'(MAX_LEN)) ? WIN : ADD;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        cnt_d   = CNT_W'(TIMEOUT_CYCLES);
                        state_d = WAIT_IN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign score = score_q;
    assign level = len_q;

endmodule

// File: tb/tb_pattern_game_core.sv
// tb/tb_pattern_game_core.sv - directed self-checking bench for pattern_game_core
module tb_pattern_game_core;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] buttons;
    logic [7:0] led;
    logic       active;
    logic       game_over;
    logic       win;
    logic [4:0] score;
    logic [1:0] level;

    int          vectors;
    int          miscompares;
    int          seq [3];
    int          wrong;
    logic [15:0] m_lfsr;

    pattern_game_core #(
        .NUM_BUTTONS    (8),
        .MAX_LEN        (3),
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20),
        .SCORE_W        (5)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .buttons   (buttons),
        .led       (led),
        .active    (active),
        .game_over (game_over),
        .win       (win),
        .score     (score),
        .level     (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference symbol source: the Galois LFSR stepping on the same clocks.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("show_on_led", {24'd0, led}, 32'd1 << seq[i]);
                if (j == 0) chk("show_level", {30'd0, level}, n);
            end
            for (int j = 0; j < 2; j++) begin
                tick();
                chk("show_off_led", {24'd0, led}, 32'd0);
            end
        end
    endtask

    task automatic press(input int s);
        buttons = 8'd1 << s;
        tick();
        chk("echo_led", {24'd0, led}, 32'd1 << s);
        buttons = 8'd0;
        tick();
    endtask

    // Entered while the DUT sits in ADD for a round of length n.
    task automatic run_round(input int n, input bit rev);
        seq[n-1] = int'(m_lfsr[2:0]);
        play(n);
        tick();
        chk("wait_in_active", {31'd0, active}, 32'd1);
        for (int i = 0; i < n; i++) begin
            press(rev ? seq[n-1-i] : seq[i]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mode        = 2'd0;
        buttons     = 8'd0;
        #22;
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_over", {31'd0, game_over}, 32'd0);
        chk("rst_win", {31'd0, win}, 32'd0);
        chk("rst_led", {24'd0, led}, 32'd0);
        chk("rst_score", {27'd0, score}, 32'd0);
        chk("rst_level", {30'd0, level}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Classic game to a win.
        mode  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_active", {31'd0, active}, 32'd1);
        run_round(1, 1'b0);
        chk("classic_score1", {27'd0, score}, 32'd1);
        run_round(2, 1'b0);
        chk("classic_score2", {27'd0, score}, 32'd2);
        run_round(3, 1'b0);
        chk("classic_score3", {27'd0, score}, 32'd3);
        chk("classic_win", {31'd0, win}, 32'd1);
        chk("classic_win_active", {31'd0, active}, 32'd0);
        chk("classic_win_level", {30'd0, level}, 32'd3);

        // Classic game lost in round 2.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_from_win", {31'd0, win}, 32'd0);
        chk("restart_score", {27'd0, score}, 32'd0);
        run_round(1, 1'b0);
        seq[1] = int'(m_lfsr[2:0]);
        play(2);
        tick();
        buttons = 8'd1 << ((seq[0] + 1) % 8);
        tick();
        buttons = 8'd0;
        chk("wrong_over", {31'd0, game_over}, 32'd1);
        chk("wrong_active", {31'd0, active}, 32'd0);
        chk("wrong_score", {27'd0, score}, 32'd1);
        tick();

        // Reverse mode, started from game over.
        mode  = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rev_restart_over", {31'd0, game_over}, 32'd0);
        chk("rev_restart_score", {27'd0, score}, 32'd0);
        run_round(1, 1'b1);
        chk("rev_score1", {27'd0, score}, 32'd1);
        run_round(2, 1'b1);
        chk("rev_score2", {27'd0, score}, 32'd2);
        seq[2] = int'(m_lfsr[2:0]);
        play(3);
        tick();
        wrong   = (seq[0] != seq[2]) ? seq[0] : (seq[2] + 1) % 8;
        buttons = 8'd1 << wrong;
        tick();
        buttons = 8'd0;
        chk("rev_forward_over", {31'd0, game_over}, 32'd1);
        tick();

        // Timed mode: press in the last allowed cycle, then at cycle 19, then time out.
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 2'd0;
        seq[0] = int'(m_lfsr[2:0]);
        play(1);
        tick();
        repeat (19) tick();
        chk("timed_c20_active", {31'd0, active}, 32'd1);
        buttons = 8'd1 << seq[0];
        tick();
        chk("timed_c20_press_over", {31'd0, game_over}, 32'd0);
        chk("timed_c20_echo", {24'd0, led}, 32'd1 << seq[0]);
        buttons = 8'd0;
        tick();
        chk("timed_score1", {27'd0, score}, 32'd1);
        seq[1] = int'(m_lfsr[2:0]);
        play(2);
        tick();
        repeat (18) tick();
        press(seq[0]);
        repeat (19) tick();
        chk("timed_reload_over", {31'd0, game_over}, 32'd0);
        chk("timed_reload_active", {31'd0, active}, 32'd1);
        tick();
        chk("timed_timeout_over", {31'd0, game_over}, 32'd1);
        chk("timed_timeout_score", {27'd0, score}, 32'd1);

        // Reset from game over, reserved mode, then reset mid-game.
        rst_n = 1'b0;
        #1;
        chk("rst_from_over", {31'd0, game_over}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        mode  = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rsvd_active", {31'd0, active}, 32'd0);
        chk("rsvd_level", {30'd0, level}, 32'd0);
        tick();
        mode  = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midgame_active", {31'd0, active}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_active", {31'd0, active}, 32'd0);
        chk("midrst_led", {24'd0, led}, 32'd0);
        chk("midrst_level", {30'd0, level}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_game_core.md
Name: pattern_game_core

Overview:
- Parametrised successor to the fixed 8-button memory-game datapath. A single FSM replaces the three per-mode FSMs.
- Generates a growing random symbol sequence and plays it back on one-hot LEDs.
- Accepts button presses and checks them against the sequence in forward order (classic and timed modes) or reversed order (reverse mode).
- Tracks rounds, score, game-over and win. Sits between the io pin mapping and the status LEDs in my_chip's successor.

Parameters:
- NUM_BUTTONS, 8, number of buttons/LEDs (2..16).
- SYM_W, $clog2(NUM_BUTTONS), symbol width (derived; do not override).
- MAX_LEN, 25, maximum sequence length; completing a round at this length is a win.
- SHOW_CYCLES, 500, clocks each symbol LED is lit during playback.
- GAP_CYCLES, 100, dark clocks after each lit symbol.
- TIMEOUT_CYCLES, 5000, timed-mode limit per press.
- SCORE_W, 5, score counter width.

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level; rising edge starts or restarts a game
- mode  in  2  0 classic, 1 timed, 2 reverse, 3 reserved
- buttons  in  NUM_BUTTONS  level, synchronised upstream; multiple bits resolve to lowest index
- led  out  NUM_BUTTONS  one-hot playback / press echo
- active  out  1  game in progress
- game_over  out  1  lost
- win  out  1  MAX_LEN completed
- score  out  SCORE_W  completed rounds, saturating
- level  out  $clog2(MAX_LEN+1)  current sequence length

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; len, idx, score, timers 0.
  - LFSR = 16'hACE1.
- Edge detection: start and the OR of buttons are each registered. An edge is current=1 while previous=0.
- LFSR:
  - 16-bit Galois, taps 16'hB400, free-running every clock, including in IDLE.
  - sym = lfsr[SYM_W-1:0]; if sym >= NUM_BUTTONS, subtract NUM_BUTTONS.
- States and transitions:
  - IDLE: on a start edge with mode != 3, latch mode, clear len and score, go to ADD. A start edge with mode 3 is ignored.
  - ADD (1 cycle): mem[len] <= sym; len <= len+1; idx <= 0; go to SHOW_ON.
  - SHOW_ON: led = onehot(mem[idx]) for SHOW_CYCLES clocks, then go to SHOW_OFF.
  - SHOW_OFF: led = 0 for GAP_CYCLES clocks.
    - If idx == len-1: idx <= 0, timer <= TIMEOUT_CYCLES, go to WAIT_IN.
    - Else idx++, go to SHOW_ON.
  - WAIT_IN: led = 0. The expected slot is idx (forward) or len-1-idx (reverse).
    - On a button edge, mismatch -> OVER.
    - Match -> WAIT_REL.
    - Timed mode only: timer decrements each clock. If it reaches 0 before a press -> OVER. A press and a timeout in the same cycle: the press wins.
  - WAIT_REL: led echoes the pressed button while held. On release:
    - If idx == len-1: score++ (saturating). If len == MAX_LEN -> WIN, else -> ADD.
    - Else idx++, timer reload, go to WAIT_IN.
  - OVER / WIN: sticky. A start edge behaves as in IDLE: new game, mode re-latched, score cleared.
- Outputs by state:
  - active = 1 in ADD, SHOW_*, WAIT_*.
  - game_over = 1 only in OVER.
  - win = 1 only in WIN.
- Start edges during an active game are ignored.
- Mode changes after latching are ignored until the next start.
- Asynchronous reset mid-game returns to IDLE immediately. Pattern memory contents are don't-care after reset.

Optional Feature:
- Macro: GAME_SPEEDUP_EN.
- When defined: the playback on-time for a round is SHOW_CYCLES - score*(SHOW_CYCLES/8), floored at SHOW_CYCLES/4.
- When undefined: on-time is always SHOW_CYCLES; the logic is absent.

Decomposition:
- Package pattern_game_pkg holds:
  - mode_t enum (MODE_CLASSIC, MODE_TIMED, MODE_REVERSE, MODE_RSVD).
  - state_t enum (IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WAIT_REL, OVER, WIN).
  - LFSR_SEED and LFSR_TAPS constants.
- One sub-module, game_lfsr: the 16-bit Galois LFSR with rst_n/clock, outputting the state.
- Pattern memory stays an inferred array inside the core.

Test Plan (NUM_BUTTONS=8, MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, SCORE_W=5):
- Reset, then mode=0 and a start edge -> active=1 one cycle after the edge; led one-hot for exactly 4 clocks, then 0 for 2; level=1.
- Classic: echo each played sequence correctly for 3 rounds -> score increments 1,2,3; then win=1, active=0, level=3.
- Classic round 2: press a wrong button -> game_over=1 next cycle, score stays 1.
- Reverse: sequence played as A,B -> press B then A -> score=2; pressing A,B instead -> game_over=1.
- Timed: in WAIT_IN, no press for 20 clocks -> game_over=1. A press at clock 19 -> accepted, timer reloads.
- Mode=3 plus start -> stays IDLE. Then, mid-game, assert rst_n=0 -> all outputs 0 immediately. Finally, start while game_over=1 -> new game, score=0, level=1.
